// File: rtl/special_mult_pkg.sv
// ---------------------------------------------------------------------------
// special_mult_pkg
// Shared constants for the special multiplier / display block:
//   - SEG_TABLE : seven-segment codes for hex digits 0..F, bit order gfedcba,
//                 1 = segment lit. Entry [n] is the code for digit n.
//   - SEG_BLANK : all segments off, used for leading-zero blanking.
//   - DEF_*_MAX : default band upper bounds for the transfer function.
// ---------------------------------------------------------------------------
package special_mult_pkg;

    localparam int DEF_LO_MAX  = 2;
    localparam int DEF_MID_MAX = 5;
    localparam int DEF_HI_MAX  = 8;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Packed so that SEG_TABLE[n] selects the code for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001,   // F
        7'b1111001,   // E
        7'b1011110,   // d
        7'b0111001,   // C
        7'b1111100,   // b
        7'b1110111,   // A
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex-nibble to seven-segment decoder.
// Ports:
//   i_nib  in   4  hex digit value
//   o_seg  out  7  segment pattern, order gfedcba, 1 = lit
// ---------------------------------------------------------------------------
module hex_to_seg7
    import special_mult_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/special_mult_display.sv
// ---------------------------------------------------------------------------
// special_mult_display
// Two-stage banded transfer function with a multiplexed hex display.
//   Stage 1 captures the operand, stage 2 registers f(op):
//     f(x) = x       for x <= LO_MAX
//            2x + 1  for LO_MAX  < x <= MID_MAX
//            2x - 1  for MID_MAX < x <= HI_MAX
//            0       otherwise
//   The registered result is scanned onto DIGITS seven-segment digits, one
//   digit per SCAN_DIV clock slot.
// Optional feature: define SPECIAL_MULT_BLANK_EN to blank leading zero digits
//   (digit 0 always shows its value).
// Ports:
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous active-high reset
//   in_valid      in   1        operand strobe
//   in_data       in   IN_W     unsigned operand
//   result        out  IN_W+1   registered result
//   result_valid  out  1        one-cycle pulse per new result
//   seg           out  7        active digit segments, gfedcba, 1 = lit
//   an            out  DIGITS   one-hot digit enable, bit 0 = LS hex digit
// ---------------------------------------------------------------------------
module special_mult_display
    import special_mult_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int LO_MAX   = DEF_LO_MAX,
    parameter int MID_MAX  = DEF_MID_MAX,
    parameter int HI_MAX   = DEF_HI_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic [IN_W:0]     result,
    output logic              result_valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int RW = IN_W + 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EW = 4 * DIGITS;

    // -----------------------------------------------------------------------
    // Datapath pipeline
    // -----------------------------------------------------------------------
    logic [IN_W-1:0] r_op;
    logic            r_v1;
    logic [RW-1:0]   r_result;
    logic            r_result_valid;

    logic [RW-1:0]   w_x;
    logic [RW-1:0]   w_dbl;
    logic [RW-1:0]   w_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid)
                r_op <= in_data;
        end
    end

    // Evaluated one bit wider than the operand so 2x+1 never overflows.
    // The 2x-1 band starts above MID_MAX >= 1, so it cannot underflow.
    assign w_x   = {1'b0, r_op};
    assign w_dbl = {r_op, 1'b0};

    always_comb begin
        w_f = '0;
        if (w_x <= RW'(LO_MAX))
            w_f = w_x;
        else if (w_x <= RW'(MID_MAX))
            w_f = w_dbl + RW'(1);
        else if (w_x <= RW'(HI_MAX))
            w_f = w_dbl - RW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= r_v1;
            if (r_v1)
                r_result <= w_f;
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;

    // -----------------------------------------------------------------------
    // Display scan
    // seg/an are reloaded only when a slot begins, using the index of the
    // slot being entered, so a result update mid-slot never disturbs the
    // digit currently shown.
    // -----------------------------------------------------------------------
    logic [PW-1:0]     r_pre;
    logic [DW-1:0]     r_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_wrap;
    logic [DW-1:0]     w_idx_nxt;
    logic [EW-1:0]     w_ext;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg_code;
    logic [6:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    assign w_wrap    = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_nxt = (r_idx == DW'(DIGITS - 1)) ? '0 : r_idx + DW'(1);
    assign w_ext     = EW'(r_result);
    assign w_nib     = w_ext[w_idx_nxt*4 +: 4];
    assign w_an_nxt  = DIGITS'(1) << w_idx_nxt;

    hex_to_seg7 u_hex_to_seg7 (
        .i_nib (w_nib),
        .o_seg (w_seg_code)
    );

`ifdef SPECIAL_MULT_BLANK_EN
    // A digit is a leading zero when it and every nibble above it are zero.
    logic [EW-1:0] w_upper;
    assign w_upper   = w_ext >> {w_idx_nxt, 2'b00};
    assign w_seg_nxt = ((w_idx_nxt != '0) && (w_upper == '0)) ? SEG_BLANK : w_seg_code;
`else
    assign w_seg_nxt = w_seg_code;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
            r_an  <= DIGITS'(1);
            r_seg <= SEG_TABLE[0];
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= w_idx_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_special_mult_display.sv
module tb_special_mult_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT0: default function/digits, short scan period
    logic       in_valid0;
    logic [3:0] in_data0;
    logic [4:0] result0;
    logic       rv0;
    logic [6:0] seg0;
    logic [1:0] an0;

    // DUT1: IN_W=5, HI_MAX=20
    logic       in_valid1;
    logic [4:0] in_data1;
    logic [5:0] result1;
    logic       rv1;
    logic [6:0] seg1;
    logic [1:0] an1;

    special_mult_display #(
        .IN_W(4), .DIGITS(2), .SCAN_DIV(3), .LO_MAX(2), .MID_MAX(5), .HI_MAX(8)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
        .result(result0), .result_valid(rv0), .seg(seg0), .an(an0)
    );

    special_mult_display #(
        .IN_W(5), .DIGITS(2), .SCAN_DIV(3), .LO_MAX(2), .MID_MAX(5), .HI_MAX(20)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .result(result1), .result_valid(rv1), .seg(seg1), .an(an1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    typedef struct { int val; int due; } exp_t;
    exp_t sbq[$];

    function automatic int f_model(int x, int lo, int mid, int hi);
        if (x <= lo)  return x;
        if (x <= mid) return 2 * x + 1;
        if (x <= hi)  return 2 * x - 1;
        return 0;
    endfunction

    function automatic logic [6:0] hex7(int n);
        case (n & 15)
            0:  return 7'b0111111;
            1:  return 7'b0000110;
            2:  return 7'b1011011;
            3:  return 7'b1001111;
            4:  return 7'b1100110;
            5:  return 7'b1101101;
            6:  return 7'b1111101;
            7:  return 7'b0000111;
            8:  return 7'b1111111;
            9:  return 7'b1101111;
            10: return 7'b1110111;
            11: return 7'b1111100;
            12: return 7'b0111001;
            13: return 7'b1011110;
            14: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Expected code for the top digit of a two-digit display.
    function automatic logic [6:0] top_digit(int n);
`ifdef SPECIAL_MULT_BLANK_EN
        if (n == 0) return 7'b0000000;
`endif
        return hex7(n);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // Scoreboard monitor for DUT0 result pulses.
    always @(negedge clk) begin
        if (!rst && rv0) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", result0, e.val);
                check("latency", cyc, e.due);
            end
        end
    end

    // Called just after a negedge; occupies one cycle.
    task automatic strobe0(int v);
        exp_t e;
        e.val = f_model(v, 2, 5, 8);
        e.due = cyc + 2;
        in_valid0 = 1'b1;
        in_data0  = v[3:0];
        sbq.push_back(e);
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    // Wait for a fresh slot of digit d on the selected DUT, then check seg.
    task automatic check_digit(int sel, int d, logic [6:0] exp, string tag);
        logic [1:0] prev, cur, want;
        bit found;
        found = 0;
        want  = (d == 0) ? 2'b01 : 2'b10;
        prev  = (sel != 0) ? an1 : an0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cur = (sel != 0) ? an1 : an0;
            if (cur != prev && cur == want) begin
                found = 1;
                break;
            end
            prev = cur;
        end
        if (!found) timeout(tag);
        else check(tag, (sel != 0) ? seg1 : seg0, exp);
    endtask

    task automatic check_scan(string tag, int n);
        for (int k = 0; k < n; k++) begin
            check(tag, an0, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid0 = 1'b0; in_data0 = '0;
        in_valid1 = 1'b0; in_data1 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_result", result0, 0);
        check("rst_valid",  rv0, 0);
        check("rst_an",     an0, 2'b01);
        check("rst_seg",    seg0, 7'b0111111);

        // Scan cadence from release: 3 slots of 01, 3 of 10, ...
        rst = 1'b0;
        check_scan("scan_an", 12);

        // 4 -> 9
        strobe0(4);
        repeat (3) @(negedge clk);
        check_digit(0, 0, hex7(9), "d0_of_9");
        check_digit(0, 1, top_digit(0), "d1_of_9");

        // 6 -> 11 shows b
        strobe0(6);
        repeat (3) @(negedge clk);
        check_digit(0, 0, hex7(11), "d0_of_11");

        // back-to-back 5,6,8 -> 11,11,15
        strobe0(5);
        strobe0(6);
        strobe0(8);
        repeat (3) @(negedge clk);
        check_digit(0, 0, hex7(15), "d0_of_15");
        check_digit(0, 1, top_digit(0), "d1_of_15");

        // every operand value back-to-back, band boundaries included
        for (int v = 0; v < 16; v++) strobe0(v);
        repeat (3) @(negedge clk);
        check("result_of_15", result0, 0);
        check_digit(0, 0, hex7(0), "d0_of_15in");

        // 9 is just above HI_MAX
        strobe0(3);
        strobe0(9);
        repeat (3) @(negedge clk);
        check("result_of_9", result0, 0);
        check_digit(0, 0, hex7(0), "d0_of_9in");

        // DUT1: 20 -> 39 = 0x27
        in_valid1 = 1'b1; in_data1 = 5'd20;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("d1_valid_early", rv1, 0);
        @(negedge clk);
        check("d1_valid", rv1, 1);
        check("d1_result", result1, 39);
        @(negedge clk);
        check("d1_pulse_len", rv1, 0);
        check_digit(1, 1, hex7(2), "dut1_d1");
        check_digit(1, 0, hex7(7), "dut1_d0");

        // DUT1: 21 is above HI_MAX
        in_valid1 = 1'b1; in_data1 = 5'd21;
        @(negedge clk);
        in_valid1 = 1'b0;
        @(negedge clk);
        check("d1_result_21", result1, 0);

        // Reset mid-slot while digit 1 is shown
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (an0 == 2'b10) begin found = 1; break; end
            end
            if (!found) timeout("wait_an10");
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("midrst_an", an0, 2'b01);
        check("midrst_seg", seg0, 7'b0111111);
        @(negedge clk);
        rst = 1'b0;
        check_scan("scan_after_rst", 7);

        // Strobe 7 then reset before the next edge: nothing may come out
        in_valid0 = 1'b1; in_data0 = 4'd7;
        @(negedge clk);
        in_valid0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_valid", rv0, 0);
            @(negedge clk);
        end
        check("flush_result", result0, 0);

        check("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/special_mult_display.md
SPECIAL_MULT_DISPLAY -- requirements
Module: special_mult_display

Interface
REQ-001 Parameter IN_W, default 4: input operand width in bits; legal range 2..12.
REQ-002 Parameter DIGITS, default 2: number of multiplexed seven-segment digits; SHALL be >= ceil((IN_W+1)/4).
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per digit scan slot; legal range >= 1.
REQ-004 Parameters LO_MAX, MID_MAX, HI_MAX, defaults 2, 5, 8: band upper bounds; SHALL satisfy LO_MAX < MID_MAX < HI_MAX < 2^IN_W.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  operand strobe; in_data sampled on every clk edge where in_valid=1.
REQ-008 in_data  input  IN_W  unsigned operand.
REQ-009 result  output  IN_W+1  registered unsigned result.
REQ-010 result_valid  output  1  one-cycle pulse marking a new result.
REQ-011 seg  output  7  segment pattern for the active digit, order gfedcba, 1=lit.
REQ-012 an  output  DIGITS  one-hot digit enable, 1=active; bit 0 = least-significant hex digit.

Function
REQ-013 Stage 1: on in_valid=1, op_q <= in_data and v1 <= 1; otherwise v1 <= 0 and op_q holds.
REQ-014 Stage 2: when v1=1, result <= f(op_q) and result_valid <= 1; otherwise result holds, result_valid <= 0.
REQ-015 f(x) = x for x <= LO_MAX; 2x+1 for LO_MAX < x <= MID_MAX; 2x-1 for MID_MAX < x <= HI_MAX; 0 for x > HI_MAX.
REQ-016 Arithmetic SHALL be IN_W+1 bits wide, no truncation; 2x-1 is never evaluated at x=0 because MID_MAX >= 1.
REQ-017 Latency: result and result_valid update 2 clk edges after the in_valid edge; back-to-back strobes yield back-to-back pulses, one per strobe, in order.
REQ-018 Prescaler counts 0..SCAN_DIV-1 and wraps; at wrap, digit index advances 0..DIGITS-1 and wraps to 0.
REQ-019 an = one-hot of digit index; seg = hex-to-seven-segment code of nibble[index] of the zero-extended result.
REQ-020 Hex codes 0-F: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111, 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
REQ-021 Digits above the result width SHALL display 0 (or blank, per REQ-026).
REQ-022 seg and an SHALL be registered; a result change is visible from the next scan slot onward, never glitching mid-slot.

Reset
REQ-023 While rst=1: op_q=0, v1=0, result=0, result_valid=0, prescaler=0, digit index=0.
REQ-024 Reset values on display: an = 1 in bit 0 only; seg = 0111111.
REQ-025 rst asserted mid-pipeline or mid-scan SHALL discard in-flight operands; no result_valid pulse follows release.

Configuration
REQ-026 With SPECIAL_MULT_BLANK_EN defined: any digit index > 0 whose nibble and all higher nibbles are 0 SHALL output seg=0000000 (leading-zero blanking); digit 0 always shows its value.
REQ-027 Without SPECIAL_MULT_BLANK_EN: all digits always show their hex code, including leading zeros.

Structure
REQ-028 Package special_mult_pkg SHALL hold the 16-entry segment code table, the blank code and the default band bounds.
REQ-029 Sub-module hex_to_seg7 (4-bit in, 7-bit out, combinational) SHALL implement REQ-020; the block instantiates it once on the muxed nibble.

Verification
REQ-030 Defaults, in_data=4 strobe -> 2 cycles later result=9, one-cycle result_valid; digit0 seg=1101111, digit1 seg=0111111 (0000000 with macro).
REQ-031 Defaults, strobes 5,6,8 on consecutive cycles -> results 11,11,15 on consecutive cycles; digit0 shows b (1111100) then F (1110001).
REQ-032 Defaults, in_data=9 and 15 -> result=0, seg=0111111 on digit0.
REQ-033 IN_W=5, DIGITS=2, HI_MAX=20, in_data=20 -> result=39 (0x27): digit1 seg=1011011, digit0 seg=0000111.
REQ-034 SCAN_DIV=3, DIGITS=2 -> an alternates 01,10 every 3 cycles; rst pulse mid-slot returns an=01, prescaler=0.
REQ-035 Strobe in_data=7 then rst on the following edge -> result stays 0, no result_valid pulse.
